// File: rtl/dmac_pri_arb.sv
// DMA channel priority arbiter: one registered one-hot grant, priority preemption at last ack.
// Define DMAC_PRI_ARB_RR_EN for round-robin tie-breaking among equal-priority channels.
module dmac_pri_arb #(
  parameter int NUM_CH = 7,
  parameter int PRI_W  = 3,
  parameter int IDX_W  = 3
) (
  input  logic                      CLK,
  input  logic                      RST_SYNC_N,
  input  logic                      EN,
  input  logic [NUM_CH-1:0]         CH_EN_IN,
  input  logic [NUM_CH*PRI_W-1:0]   CH_PRI_IN,
  input  logic [NUM_CH-1:0]         REQ_IN,
  input  logic                      BUS_LAST_ACK_IN,
  output logic [NUM_CH-1:0]         CH_SEL_OUT,
  output logic                      GNT_VLD_OUT,
  output logic [IDX_W-1:0]          GNT_IDX_OUT,
  output logic                      PREEMPT_OUT
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [NUM_CH-1:0]   sel_r, sel_nxt_s;
  logic [IDX_W-1:0]    idx_r, idx_nxt_s;
  logic                vld_r, vld_nxt_s;
  logic                pre_r, pre_nxt_s;
  logic [NUM_CH-1:0]   elig_s;
  logic [PRI_W-1:0]    min_pri_s, cur_pri_s;
  logic [IDX_W-1:0]    win_s;
  logic                cur_elig_s;
  logic                any_s;
  logic                take_s;
`ifdef DMAC_PRI_ARB_RR_EN
  logic [IDX_W-1:0]    ptr_r;
`endif

  assign elig_s = CH_EN_IN & REQ_IN;
  assign any_s  = |elig_s;

  // Winner selection: lowest priority value, then tie-break; also the held channel's status.
  always_comb begin
    min_pri_s  = {PRI_W{1'b1}};
    cur_pri_s  = {PRI_W{1'b1}};
    cur_elig_s = 1'b0;
    win_s      = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      min_pri_s  = (elig_s[i] && (CH_PRI_IN[i*PRI_W +: PRI_W] < min_pri_s)) ?
                   CH_PRI_IN[i*PRI_W +: PRI_W] : min_pri_s;
      cur_pri_s  = (i == int'(idx_r)) ? CH_PRI_IN[i*PRI_W +: PRI_W] : cur_pri_s;
      cur_elig_s = (i == int'(idx_r)) ? elig_s[i] : cur_elig_s;
    end
`ifdef DMAC_PRI_ARB_RR_EN
    // Walk the search order backwards so the first hit after the pointer is the last written.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_r) + 1 + k;
      j = (j >= NUM_CH) ? (j - NUM_CH) : j;
      win_s = (elig_s[j] && (CH_PRI_IN[j*PRI_W +: PRI_W] == min_pri_s)) ? IDX_W'(j) : win_s;
    end
    take_s = BUS_LAST_ACK_IN && (win_s != idx_r);
`else
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      win_s = (elig_s[k] && (CH_PRI_IN[k*PRI_W +: PRI_W] == min_pri_s)) ? IDX_W'(k) : win_s;
    end
    take_s = BUS_LAST_ACK_IN && (min_pri_s < cur_pri_s);
`endif
  end

  // Next-state and next-output logic for the IDLE/BUSY grant machine.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    idx_nxt_s   = idx_r;
    vld_nxt_s   = vld_r;
    pre_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          state_nxt_s = ST_BUSY;
          sel_nxt_s   = {{(NUM_CH-1){1'b0}}, 1'b1} << win_s;
          idx_nxt_s   = win_s;
          vld_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!cur_elig_s) begin
          if (any_s) begin
            sel_nxt_s   = {{(NUM_CH-1){1'b0}}, 1'b1} << win_s;
            idx_nxt_s   = win_s;
          end else begin
            state_nxt_s = ST_IDLE;
            sel_nxt_s   = {NUM_CH{1'b0}};
            idx_nxt_s   = {IDX_W{1'b0}};
            vld_nxt_s   = 1'b0;
          end
        end else if (take_s) begin
          sel_nxt_s = {{(NUM_CH-1){1'b0}}, 1'b1} << win_s;
          idx_nxt_s = win_s;
          pre_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        sel_nxt_s   = {NUM_CH{1'b0}};
        idx_nxt_s   = {IDX_W{1'b0}};
        vld_nxt_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; EN low freezes everything but forces the preempt pulse low.
  always_ff @(posedge CLK) begin
    if (!RST_SYNC_N) begin
      state_r <= ST_IDLE;
      sel_r   <= {NUM_CH{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      vld_r   <= 1'b0;
      pre_r   <= 1'b0;
`ifdef DMAC_PRI_ARB_RR_EN
      ptr_r   <= IDX_W'(NUM_CH - 1);
`endif
    end else if (EN) begin
      state_r <= state_nxt_s;
      sel_r   <= sel_nxt_s;
      idx_r   <= idx_nxt_s;
      vld_r   <= vld_nxt_s;
      pre_r   <= pre_nxt_s;
`ifdef DMAC_PRI_ARB_RR_EN
      ptr_r   <= vld_nxt_s ? idx_nxt_s : ptr_r;
`endif
    end else begin
      pre_r   <= 1'b0;
    end
  end

  assign CH_SEL_OUT  = sel_r;
  assign GNT_VLD_OUT = vld_r;
  assign GNT_IDX_OUT = idx_r;
  assign PREEMPT_OUT = pre_r;

endmodule

// File: tb/tb_dmac_pri_arb.sv
// Self-checking bench for dmac_pri_arb: per-cycle behavioural model compare plus directed literals.
module tb_dmac_pri_arb;
  localparam int N  = 7;
  localparam int PW = 3;
  localparam int IW = 3;
`ifdef DMAC_PRI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST_SYNC_N, EN, BUS_LAST_ACK_IN;
  logic [N-1:0]    CH_EN_IN, REQ_IN, CH_SEL_OUT;
  logic [N*PW-1:0] CH_PRI_IN;
  logic            GNT_VLD_OUT, PREEMPT_OUT;
  logic [IW-1:0]   GNT_IDX_OUT;
  logic [PW-1:0]   pri [N];

  dmac_pri_arb dut (
    .CLK(CLK), .RST_SYNC_N(RST_SYNC_N), .EN(EN), .CH_EN_IN(CH_EN_IN),
    .CH_PRI_IN(CH_PRI_IN), .REQ_IN(REQ_IN), .BUS_LAST_ACK_IN(BUS_LAST_ACK_IN),
    .CH_SEL_OUT(CH_SEL_OUT), .GNT_VLD_OUT(GNT_VLD_OUT), .GNT_IDX_OUT(GNT_IDX_OUT),
    .PREEMPT_OUT(PREEMPT_OUT)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < N; i++) CH_PRI_IN[i*PW +: PW] = pri[i];
  end

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Model: g is the granted channel (-1 when idle), mptr the round-robin pointer.
  int g = -1;
  int mptr = N - 1;
  bit mpre = 1'b0;
  int best, bp, c;
  bit moved;

  function automatic bit el(int i);
    return CH_EN_IN[i] & REQ_IN[i];
  endfunction

  always @(posedge CLK) begin
    if (!RST_SYNC_N) begin
      g = -1; mptr = N - 1; mpre = 1'b0;
    end else if (!EN) begin
      mpre = 1'b0;
    end else begin
      bp = 1 << PW;
      best = -1;
      for (int i = 0; i < N; i++) if (el(i) && int'(pri[i]) < bp) bp = int'(pri[i]);
      for (int k = 0; k < N; k++) begin
        c = RR ? (mptr + 1 + k) % N : k;
        if (best < 0 && el(c) && int'(pri[c]) == bp) best = c;
      end
      mpre = 1'b0;
      moved = 1'b0;
      if (g < 0 || !el(g)) begin
        g = best;
      end else if (BUS_LAST_ACK_IN) begin
        // fixed mode: only a strictly more urgent channel takes over; RR: equal ones too
        for (int i = 0; i < N; i++)
          if (i != g && el(i) && (pri[i] < pri[g] || (RR && pri[i] == pri[g]))) moved = 1'b1;
        if (moved) begin g = best; mpre = 1'b1; end
      end
      if (RR && g >= 0) mptr = g;
    end
  end

  logic [N-1:0]  exp_sel;
  logic [IW-1:0] exp_idx;

  always @(negedge CLK) begin
    if (chk_on) begin
      exp_sel = '0;
      exp_idx = '0;
      if (g >= 0) begin exp_sel[g] = 1'b1; exp_idx = IW'(g); end
      n_chk++;
      if (CH_SEL_OUT !== exp_sel || GNT_VLD_OUT !== (g >= 0) ||
          GNT_IDX_OUT !== exp_idx || PREEMPT_OUT !== mpre) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t actual sel=%h vld=%b idx=%0d pre=%b required sel=%h vld=%b idx=%0d pre=%b",
                 $time, CH_SEL_OUT, GNT_VLD_OUT, GNT_IDX_OUT, PREEMPT_OUT,
                 exp_sel, (g >= 0), exp_idx, mpre);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic lit(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic outs(string nm, logic [N-1:0] sel, int idx, bit pre);
    lit({nm, "_sel"}, 32'(CH_SEL_OUT), 32'(sel));
    lit({nm, "_vld"}, 32'(GNT_VLD_OUT), 32'(sel != '0));
    lit({nm, "_idx"}, 32'(GNT_IDX_OUT), 32'(idx));
    lit({nm, "_pre"}, 32'(PREEMPT_OUT), 32'(pre));
  endtask

  task automatic pri_all(logic [PW-1:0] p);
    for (int i = 0; i < N; i++) pri[i] = p;
  endtask

  int seq [3];
  int e;

  initial begin
    seq = '{2, 4, 0};
    RST_SYNC_N = 1'b0; EN = 1'b1; CH_EN_IN = 7'h7F; REQ_IN = 7'h00; BUS_LAST_ACK_IN = 1'b0;
    pri_all(3'd3);
    step(1);
    chk_on = 1'b1;
    step(1);
    outs("reset", 7'h00, 0, 1'b0);

    // request held through reset: nothing until reset is sampled high
    REQ_IN = 7'h14;
    step(1);
    outs("in_reset", 7'h00, 0, 1'b0);
    RST_SYNC_N = 1'b1;
    step(1);
    outs("first_grant", 7'h04, 2, 1'b0);
    REQ_IN = 7'h00;
    step(1);
    outs("idle1", 7'h00, 0, 1'b0);

    // higher priority waits for last ack, then preempts
    pri[5] = 3'd4; pri[1] = 3'd1; REQ_IN = 7'h20;
    step(1);
    outs("ch5", 7'h20, 5, 1'b0);
    REQ_IN = 7'h22;
    for (int i = 0; i < 3; i++) begin
      step(1);
      outs("hold_noack", 7'h20, 5, 1'b0);
    end
    BUS_LAST_ACK_IN = 1'b1;
    step(1);
    outs("preempt", 7'h02, 1, 1'b1);
    BUS_LAST_ACK_IN = 1'b0;
    step(1);
    outs("post_preempt", 7'h02, 1, 1'b0);
    REQ_IN = 7'h00;
    step(1);

    // granted channel drops: direct handover, then idle
    pri_all(3'd3);
    REQ_IN = 7'h08;
    step(1);
    outs("ch3", 7'h08, 3, 1'b0);
    REQ_IN = 7'h40;
    step(1);
    outs("handover", 7'h40, 6, 1'b0);
    REQ_IN = 7'h00;
    step(1);
    outs("idle2", 7'h00, 0, 1'b0);

    // disabled channels never win
    REQ_IN = 7'h7F; CH_EN_IN = 7'h00;
    step(2);
    outs("all_disabled", 7'h00, 0, 1'b0);
    CH_EN_IN = 7'h08;
    step(1);
    outs("enable_ch3", 7'h08, 3, 1'b0);

    // priority change does not revoke; applies at the ack
    CH_EN_IN = 7'h7F; pri[3] = 3'd7;
    step(1);
    outs("pri_change_hold", 7'h08, 3, 1'b0);
    BUS_LAST_ACK_IN = 1'b1;
    step(1);
    e = RR ? 4 : 0;
    outs("pri_change_ack", N'(1) << e, e, 1'b1);
    BUS_LAST_ACK_IN = 1'b0; pri[3] = 3'd3; REQ_IN = 7'h00;
    step(1);

    // ack while idle is ignored
    BUS_LAST_ACK_IN = 1'b1;
    step(1);
    outs("idle_ack", 7'h00, 0, 1'b0);
    BUS_LAST_ACK_IN = 1'b0;

    // EN low freezes and kills the preempt pulse; reset overrides EN
    pri[5] = 3'd4; pri[1] = 3'd1; REQ_IN = 7'h20;
    step(1);
    REQ_IN = 7'h22; BUS_LAST_ACK_IN = 1'b1;
    step(1);
    outs("preempt2", 7'h02, 1, 1'b1);
    EN = 1'b0; BUS_LAST_ACK_IN = 1'b0; REQ_IN = 7'h00;
    step(1);
    outs("frozen1", 7'h02, 1, 1'b0);
    step(1);
    outs("frozen2", 7'h02, 1, 1'b0);
    RST_SYNC_N = 1'b0;
    step(1);
    outs("reset_en_low", 7'h00, 0, 1'b0);
    RST_SYNC_N = 1'b1; EN = 1'b1;
    pri_all(3'd3);

    // equal-priority set: RR rotates at each ack, fixed holds ch0
    RST_SYNC_N = 1'b0;
    step(1);
    RST_SYNC_N = 1'b1; REQ_IN = 7'h15;
    step(1);
    outs("eq_first", 7'h01, 0, 1'b0);
    e = 0;
    for (int r = 0; r < 3; r++) begin
      step(3);
      outs("eq_hold", N'(1) << e, e, 1'b0);
      BUS_LAST_ACK_IN = 1'b1;
      step(1);
      BUS_LAST_ACK_IN = 1'b0;
      e = RR ? seq[r] : 0;
      outs("eq_ack", N'(1) << e, e, RR);
    end
    REQ_IN = 7'h00;
    step(2);
    outs("final_idle", 7'h00, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmac_pri_arb.md
DMAC_PRI_ARB -- requirements
Module: dmac_pri_arb

Interface
REQ-001 Parameter NUM_CH, default 7, number of DMA channels arbitrated (2..16).
REQ-002 Parameter PRI_W, default 3, width of each channel priority field; value 0 is highest priority.
REQ-003 Parameter IDX_W, default 3, width of binary grant index; SHALL equal ceil(log2(NUM_CH)).
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RST_SYNC_N  input  1  reset, synchronous, active-low.
REQ-006 EN  input  1  clock enable; all state advances only when high.
REQ-007 CH_EN_IN  input  NUM_CH  per-channel enable (PCR enable bits).
REQ-008 CH_PRI_IN  input  NUM_CH*PRI_W  per-channel priority; channel n occupies bits [n*PRI_W +: PRI_W].
REQ-009 REQ_IN  input  NUM_CH  per-channel DMA request.
REQ-010 BUS_LAST_ACK_IN  input  1  last bus acknowledge of the granted channel's current transfer.
REQ-011 CH_SEL_OUT  output  NUM_CH  registered one-hot grant, all-zero when idle.
REQ-012 GNT_VLD_OUT  output  1  registered; high when CH_SEL_OUT is non-zero.
REQ-013 GNT_IDX_OUT  output  IDX_W  registered binary index of granted channel, 0 when idle.
REQ-014 PREEMPT_OUT  output  1  registered one-cycle pulse when a grant changes by preemption.

Function
REQ-015 Eligible set SHALL be CH_EN_IN & REQ_IN; disabled channels never win.
REQ-016 Winner SHALL be the eligible channel with the numerically lowest CH_PRI_IN; ties go to the lowest index (see REQ-030 for the alternative).
REQ-017 State machine SHALL have two states: IDLE (no grant) and BUSY (one grant held).
REQ-018 IDLE, EN high, eligible set non-empty: next cycle -> BUSY, CH_SEL_OUT = one-hot(winner); latency is exactly 1 cycle from request to grant.
REQ-019 BUSY, granted channel no longer eligible (REQ or CH_EN low): next cycle grant = winner of the remaining eligible set, or -> IDLE with outputs zero if none; no idle gap is inserted.
REQ-020 BUSY, granted channel still eligible, BUS_LAST_ACK_IN high, and an eligible channel with strictly lower priority value exists: next cycle grant = winner, and PREEMPT_OUT pulses high for that one cycle.
REQ-021 BUSY otherwise: grant held unchanged, including an equal-priority waiter in fixed mode and a higher-priority waiter without BUS_LAST_ACK_IN.
REQ-022 BUS_LAST_ACK_IN in IDLE SHALL be ignored.
REQ-023 CH_PRI_IN changes SHALL never revoke the current grant; new values apply only at the next evaluation point (REQ-019/020).
REQ-024 EN low SHALL freeze all registers; PREEMPT_OUT SHALL NOT be stretched (it is driven low when EN is low).
REQ-025 CH_SEL_OUT SHALL always be zero or one-hot; GNT_VLD_OUT and GNT_IDX_OUT SHALL be consistent with CH_SEL_OUT in every cycle.

Reset
REQ-026 RST_SYNC_N low at a clock edge SHALL force IDLE: CH_SEL_OUT=0, GNT_VLD_OUT=0, GNT_IDX_OUT=0, PREEMPT_OUT=0, round-robin pointer=NUM_CH-1.
REQ-027 Reset SHALL take priority over EN and abort any grant mid-transfer without waiting for BUS_LAST_ACK_IN.
REQ-028 First grant after reset release SHALL appear no earlier than 1 cycle after RST_SYNC_N is sampled high.

Configuration
REQ-029 Macro DMAC_PRI_ARB_RR_EN SHALL select round-robin tie-breaking among equal-priority channels.
REQ-030 With DMAC_PRI_ARB_RR_EN defined: ties SHALL be resolved by searching upward from (pointer+1) modulo NUM_CH; the pointer SHALL update to each newly granted index; an eligible equal-priority waiter SHALL take over at BUS_LAST_ACK_IN (PREEMPT_OUT pulses).
REQ-031 Without the macro: ties go to the lowest index, no pointer register exists, and equal priority never preempts.

Verification
REQ-032 Reset, then REQ_IN=7'h14, CH_EN_IN=7'h7F, all priorities 3 -> one cycle later CH_SEL_OUT=7'h04, GNT_IDX_OUT=2.
REQ-033 Ch5 granted at priority 4; ch1 requests at priority 1; BUS_LAST_ACK_IN low 3 cycles, then high -> grant stays 7'h20 until one cycle after the ack, then becomes 7'h02 with PREEMPT_OUT=1 for one cycle.
REQ-034 Ch3 granted, ch3 REQ drops, ch6 requesting -> next cycle CH_SEL_OUT=7'h40 and PREEMPT_OUT=0; then ch6 drops -> IDLE, all outputs 0.
REQ-035 REQ_IN=7'h7F, CH_EN_IN=7'h00 -> CH_SEL_OUT stays 0; set CH_EN_IN=7'h08 -> grant 7'h08 one cycle later.
REQ-036 RR build, ch0/ch2/ch4 requesting at equal priority, BUS_LAST_ACK_IN pulsed every 4 cycles -> grants cycle 0,2,4,0; fixed build -> ch0 held throughout.
REQ-037 Assert RST_SYNC_N low mid-grant with EN low -> all outputs 0 at the next edge.
